// File: rtl/alu8_pkg.sv
// alu8_pkg: shared width, iteration count and multiplier state encoding
package alu8_pkg;
  localparam int ALU_W = 8;
  localparam int MUL_ITER = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/mul8_seq_if.sv
// mul8_seq_if: start/operand request and product/status response bundle
interface mul8_seq_if import alu8_pkg::*; ();
  logic start;
  logic [ALU_W-1:0] a;
  logic [ALU_W-1:0] b;
  logic busy;
  logic done;
  logic [2*ALU_W-1:0] p;
  modport master(output start, a, b, input busy, done, p);
  modport slave(input start, a, b, output busy, done, p);
endinterface

// File: rtl/Cong8.sv
// Cong8: 8-bit ripple-carry adder with carry-in and carry-out
module Cong8 import alu8_pkg::*; (
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic             i_cin,
  output logic [ALU_W-1:0] o_s,
  output logic             o_cout
);
  logic [ALU_W:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar g = 0; g < ALU_W; g++) begin : g_fa
    assign o_s[g] = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end
  assign o_cout = w_c[ALU_W];
endmodule

// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 unsigned shift-and-add multiplier around Cong8
module mul8_seq import alu8_pkg::*; (
  input logic       clk,
  input logic       rst,
  mul8_seq_if.slave bus
);
  mul_state_t       r_state;
  logic [ALU_W-1:0] r_mcand;
  logic [ALU_W-1:0] r_acc;
  logic [ALU_W-1:0] r_mq;
  logic [2:0]       r_cnt;
  logic [2*ALU_W-1:0] r_p;
  logic [ALU_W-1:0] w_s;
  logic             w_cout;
  Cong8 u_add (
    .i_a   (r_acc),
    .i_b   (r_mq[0] ? r_mcand : '0),
    .i_cin (1'b0),
    .o_s   (w_s),
    .o_cout(w_cout)
  );
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.p    = r_p;
  // control FSM plus accumulator/multiplier shift; carry-out shifts into acc msb
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        RUN: begin
          {r_acc, r_mq} <= {w_cout, w_s, r_mq[ALU_W-1:1]};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(MUL_ITER - 1)) begin
            r_p     <= {w_cout, w_s, r_mq[ALU_W-1:1]};
            r_state <= DONE;
          end
        end
        IDLE, DONE: begin
          if (bus.start) begin
            r_mcand <= bus.a;
            r_mq    <= bus.b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed vector table plus multi-cycle corner sequences
module tb_mul8_seq;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[8];
  mul8_seq_if bus ();
  mul8_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic mul(input logic [7:0] x, input logic [7:0] y, output logic [15:0] pr, output int lat);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) lat++;
      @(negedge clk);
    end
    pr = bus.p;
  endtask
  initial begin
    logic [15:0] pr;
    int lat, nd, k, bad;
    vecs[0] = '{8'd13, 8'd11, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{8'hA5, 8'h5A, 16'h3A02};
    vecs[7] = '{8'h12, 8'h34, 16'h03A8};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_p", 32'(bus.p), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    check("idle_quiet", 32'(nd), 32'h0);
    for (int i = 0; i < 8; i++) begin
      mul(vecs[i].a, vecs[i].b, pr, lat);
      check($sformatf("vec%0d_p", i), 32'(pr), 32'(vecs[i].p));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(bus.done), 32'h0);
      check($sformatf("vec%0d_hold", i), 32'(bus.p), 32'(vecs[i].p));
    end
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd9;
    @(negedge clk);
    bus.a = 8'd3;
    bus.b = 8'd3;
    k = 0;
    while (!bus.done && k < 30) begin
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check("hold_start_p", 32'(bus.p), 32'h003F);
    check("hold_start_lat", 32'(k), 32'd8);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("hold_start_one_done", 32'(nd), 32'h0);
    mul(8'd5, 8'd6, pr, lat);
    check("b2b_first_p", 32'(pr), 32'h001E);
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd8;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accept_busy", 32'(bus.busy), 32'h1);
    check("b2b_accept_done", 32'(bus.done), 32'h0);
    k = 1;
    bad = 0;
    while (!bus.done && k < 30) begin
      if (bus.p !== 16'h001E) bad++;
      @(negedge clk);
      k++;
    end
    check("b2b_gap", 32'(k), 32'd9);
    check("b2b_p_held", 32'(bad), 32'h0);
    check("b2b_second_p", 32'(bus.p), 32'h0038);
    bus.start = 1'b1;
    bus.a = 8'd200;
    bus.b = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    check("midrst_p", 32'(bus.p), 32'h0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'h0);
    mul(8'd2, 8'd3, pr, lat);
    check("after_rst_p", 32'(pr), 32'h0006);
    check("after_rst_lat", 32'(lat), 32'd8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
